// File: rtl/alu_issue_queue.sv
// alu_issue_queue: parametrised ALU reservation station / issue queue.
// Holds renamed uops, snoops NUM_WK wakeup ports, and issues the oldest
// entry with both operands ready over a valid/ready handshake.
// Optional macro ALU_IQ_WAKEUP_BYPASS_EN: select also treats operands
// matching a same-cycle wakeup as ready (zero-cycle wakeup-to-issue).
`timescale 1ns/1ps
module alu_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int NUM_WK = 2,
    parameter int PREG_W = 7,
    parameter int ROB_W  = 4,
    parameter int OPC_W  = 7,
    parameter int IMM_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OPC_W-1:0]           disp_opcode,
    input  logic [PREG_W-1:0]          disp_prd,
    input  logic [PREG_W-1:0]          disp_pr1,
    input  logic [PREG_W-1:0]          disp_pr2,
    input  logic                       disp_pr1_ready,
    input  logic                       disp_pr2_ready,
    input  logic [IMM_W-1:0]           disp_imm,
    input  logic [1:0]                 disp_fu,
    input  logic [ROB_W-1:0]           disp_rob_index,
    input  logic [NUM_WK-1:0]          wk_valid,
    input  logic [NUM_WK*PREG_W-1:0]   wk_preg,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OPC_W-1:0]           iss_opcode,
    output logic [PREG_W-1:0]          iss_prd,
    output logic [PREG_W-1:0]          iss_pr1,
    output logic [PREG_W-1:0]          iss_pr2,
    output logic [IMM_W-1:0]           iss_imm,
    output logic [1:0]                 iss_fu,
    output logic [ROB_W-1:0]           iss_rob_index,
    output logic [$clog2(DEPTH):0]     free_count
);
    localparam int AGE_W = $clog2(DEPTH);
    localparam int CNT_W = AGE_W + 1;

    // Entry storage; age = number of younger valid entries.
    logic [DEPTH-1:0]              e_vld;
    logic [DEPTH-1:0][OPC_W-1:0]   e_opc;
    logic [DEPTH-1:0][PREG_W-1:0]  e_prd;
    logic [DEPTH-1:0][PREG_W-1:0]  e_pr1;
    logic [DEPTH-1:0][PREG_W-1:0]  e_pr2;
    logic [DEPTH-1:0]              e_pr1_rdy;
    logic [DEPTH-1:0]              e_pr2_rdy;
    logic [DEPTH-1:0][IMM_W-1:0]   e_imm;
    logic [DEPTH-1:0][1:0]         e_fu;
    logic [DEPTH-1:0][ROB_W-1:0]   e_rob;
    logic [DEPTH-1:0][AGE_W-1:0]   e_age;

    logic [DEPTH-1:0] wk1, wk2, cand;
    logic             wk_d1, wk_d2;
    logic             sel_found;
    logic [AGE_W-1:0] sel_idx, sel_age, alloc_idx;
    logic             do_disp, do_issue;

    function automatic logic wk_hit(input logic [NUM_WK-1:0] v,
                                    input logic [NUM_WK*PREG_W-1:0] tags,
                                    input logic [PREG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_WK; i++)
            if (v[i] && tags[i*PREG_W +: PREG_W] == tag) hit = 1'b1;
        return hit;
    endfunction

    // Match every stored source tag and the dispatching sources against the wakeup ports
    always_comb begin
        wk1 = '0;
        wk2 = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wk1[e] = wk_hit(wk_valid, wk_preg, e_pr1[e]);
            wk2[e] = wk_hit(wk_valid, wk_preg, e_pr2[e]);
        end
        wk_d1 = wk_hit(wk_valid, wk_preg, disp_pr1);
        wk_d2 = wk_hit(wk_valid, wk_preg, disp_pr2);
    end

    // Oldest-ready select: among ready entries pick the largest age
    always_comb begin
        cand      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int e = 0; e < DEPTH; e++) begin
`ifdef ALU_IQ_WAKEUP_BYPASS_EN
            cand[e] = e_vld[e] & (e_pr1_rdy[e] | wk1[e]) & (e_pr2_rdy[e] | wk2[e]);
`else
            cand[e] = e_vld[e] & e_pr1_rdy[e] & e_pr2_rdy[e];
`endif
            if (cand[e] && (!sel_found || e_age[e] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = AGE_W'(e);
                sel_age   = e_age[e];
            end
        end
    end

    // Free-entry count and lowest-index free slot for allocation
    always_comb begin
        free_count = '0;
        alloc_idx  = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (!e_vld[e]) begin
                free_count = free_count + CNT_W'(1);
                alloc_idx  = AGE_W'(e);
            end
        end
    end

    assign disp_ready = !reset && (free_count != '0);
    assign iss_valid  = sel_found && !flush && !reset;
    assign do_issue   = iss_valid && iss_ready;
    assign do_disp    = disp_valid && disp_ready && !flush;

    assign iss_opcode    = e_opc[sel_idx];
    assign iss_prd       = e_prd[sel_idx];
    assign iss_pr1       = e_pr1[sel_idx];
    assign iss_pr2       = e_pr2[sel_idx];
    assign iss_imm       = e_imm[sel_idx];
    assign iss_fu        = e_fu[sel_idx];
    assign iss_rob_index = e_rob[sel_idx];

    // Entry update: flush beats issue beats dispatch; ages track relative order
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            e_vld <= '0;
            e_age <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (do_issue && sel_idx == AGE_W'(e)) begin
                    e_vld[e] <= 1'b0;
                end else if (e_vld[e]) begin
                    // Younger issued entry leaving shrinks our age; a new dispatch grows it.
                    e_age[e] <= e_age[e] + AGE_W'(do_disp)
                                - AGE_W'(do_issue && (sel_age < e_age[e]));
                    if (wk1[e]) e_pr1_rdy[e] <= 1'b1;
                    if (wk2[e]) e_pr2_rdy[e] <= 1'b1;
                end else if (do_disp && alloc_idx == AGE_W'(e)) begin
                    e_vld[e]     <= 1'b1;
                    e_age[e]     <= '0;
                    e_opc[e]     <= disp_opcode;
                    e_prd[e]     <= disp_prd;
                    e_pr1[e]     <= disp_pr1;
                    e_pr2[e]     <= disp_pr2;
                    e_pr1_rdy[e] <= disp_pr1_ready | wk_d1;
                    e_pr2_rdy[e] <= disp_pr2_ready | wk_d2;
                    e_imm[e]     <= disp_imm;
                    e_fu[e]      <= disp_fu;
                    e_rob[e]     <= disp_rob_index;
                end
            end
        end
    end
endmodule
